// File: rtl/router_pkg.sv
// Shared types and constants for the router packet protocol.
package router_pkg;
  localparam int DATA_WIDTH = 8;
  localparam int LEN_WIDTH  = 6;
  localparam int ADDR_WIDTH = 2;
  localparam int BUF_DEPTH  = 1 << LEN_WIDTH;

  localparam logic [LEN_WIDTH-1:0]  MAX_PAYLOAD  = 6'd63;
  localparam logic [ADDR_WIDTH-1:0] INVALID_ADDR = 2'b11;

  typedef enum logic [2:0] {
    IDLE,
    HEADER,
    PAYLOAD,
    PARITY,
    GAP
  } tx_state_e;

  typedef struct packed {
    logic [LEN_WIDTH-1:0]  len;
    logic [ADDR_WIDTH-1:0] addr;
    logic                  corrupt;
  } tx_req_t;

  function automatic logic [DATA_WIDTH-1:0] pack_header(
    input logic [LEN_WIDTH-1:0]  len,
    input logic [ADDR_WIDTH-1:0] addr
  );
    return {len, addr};
  endfunction
endpackage

// File: rtl/packet_transmitter_if.sv
// Client request + router output signals of the packet transmitter.
interface packet_transmitter_if;
  import router_pkg::*;

  logic                  i_Wr_En;
  logic [DATA_WIDTH-1:0] i_Wr_Data;
  logic                  i_Start;
  logic [ADDR_WIDTH-1:0] i_Dest_Address;
  logic                  i_Corrupt_Parity;
  logic                  i_Sig_Busy;
  logic                  o_Sig_Packet_Valid;
  logic [DATA_WIDTH-1:0] o_Output_Data;
  logic                  o_Tx_Busy;
  logic                  o_Done;
  logic                  o_Req_Error;

  modport slave (
    input  i_Wr_En, i_Wr_Data, i_Start, i_Dest_Address, i_Corrupt_Parity, i_Sig_Busy,
    output o_Sig_Packet_Valid, o_Output_Data, o_Tx_Busy, o_Done, o_Req_Error
  );

  modport master (
    output i_Wr_En, i_Wr_Data, i_Start, i_Dest_Address, i_Corrupt_Parity, i_Sig_Busy,
    input  o_Sig_Packet_Valid, o_Output_Data, o_Tx_Busy, o_Done, o_Req_Error
  );
endinterface

// File: rtl/tx_payload_buffer.sv
// Payload RAM: synchronous write, asynchronous read by index; not reset.
module tx_payload_buffer
  import router_pkg::*;
(
  input  logic                  clk,
  input  logic                  wr_en,
  input  logic [LEN_WIDTH-1:0]  wr_idx,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic [LEN_WIDTH-1:0]  rd_idx,
  output logic [DATA_WIDTH-1:0] rd_data
);
  logic [DATA_WIDTH-1:0] mem [BUF_DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_idx] <= wr_data;
  end

  assign rd_data = mem[rd_idx];
endmodule

// File: rtl/packet_transmitter.sv
// Buffers client payload and emits header/payload/parity packets to a router input.
module packet_transmitter
  import router_pkg::*;
(
  input  logic                 clk,
  input  logic                 reset,
  packet_transmitter_if.slave  bus
);
  tx_state_e             state_q, state_d;
  logic [LEN_WIDTH-1:0]  count_q, count_d;
  logic [LEN_WIDTH-1:0]  idx_q, idx_d;
  tx_req_t               req_q, req_d;
  logic [DATA_WIDTH-1:0] parity_q, parity_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic                  valid_q, valid_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic                  err_q, err_d;

  logic                  wr_en;
  logic [DATA_WIDTH-1:0] rd_data;
  logic                  stall;
  logic                  in_pkt;
  logic                  start_ok;

  tx_payload_buffer u_buf (
    .clk     (clk),
    .wr_en   (wr_en),
    .wr_idx  (count_q),
    .wr_data (bus.i_Wr_Data),
    .rd_idx  (idx_q),
    .rd_data (rd_data)
  );

  // busy_q still covers the cycle where the done pulse is on the wire.
  assign in_pkt   = (state_q != IDLE) || busy_q;
  assign stall    = bus.i_Sig_Busy && (state_q inside {HEADER, PAYLOAD, PARITY});
  assign start_ok = bus.i_Start && (count_q != '0) && (bus.i_Dest_Address != INVALID_ADDR);

  always_comb begin
    state_d  = state_q;
    count_d  = count_q;
    idx_d    = idx_q;
    req_d    = req_q;
    parity_d = parity_q;
    data_d   = data_q;
    valid_d  = valid_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    err_d    = 1'b0;
    wr_en    = 1'b0;

    if (in_pkt) begin
      err_d = bus.i_Wr_En | bus.i_Start;
    end else begin
      if (bus.i_Start && !start_ok) err_d = 1'b1;
      if (start_ok) begin
        req_d   = '{len: count_q, addr: bus.i_Dest_Address, corrupt: bus.i_Corrupt_Parity};
        state_d = HEADER;
        if (bus.i_Wr_En) err_d = 1'b1;
      end else if (bus.i_Wr_En) begin
        if (count_q == MAX_PAYLOAD) begin
          err_d = 1'b1;
        end else begin
          wr_en   = 1'b1;
          count_d = count_q + 1'b1;
        end
      end
    end

    case (state_q)
      IDLE: begin
        data_d  = '0;
        valid_d = 1'b0;
        busy_d  = 1'b0;
      end
      HEADER: if (!stall) begin
        data_d   = pack_header(req_q.len, req_q.addr);
        parity_d = pack_header(req_q.len, req_q.addr);
        valid_d  = 1'b1;
        busy_d   = 1'b1;
        idx_d    = '0;
        state_d  = PAYLOAD;
      end
      PAYLOAD: if (!stall) begin
        data_d   = rd_data;
        parity_d = parity_q ^ rd_data;
        idx_d    = idx_q + 1'b1;
        if (idx_q + 1'b1 == req_q.len) state_d = PARITY;
      end
      PARITY: if (!stall) begin
        data_d  = parity_q ^ {{(DATA_WIDTH-1){1'b0}}, req_q.corrupt};
        valid_d = 1'b0;
        state_d = GAP;
      end
      GAP: begin
        data_d  = '0;
        valid_d = 1'b0;
        done_d  = 1'b1;
        count_d = '0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q  <= IDLE;
      count_q  <= '0;
      idx_q    <= '0;
      req_q    <= '0;
      parity_q <= '0;
      data_q   <= '0;
      valid_q  <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      idx_q    <= idx_d;
      req_q    <= req_d;
      parity_q <= parity_d;
      data_q   <= data_d;
      valid_q  <= valid_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      err_q    <= err_d;
    end
  end

  assign bus.o_Sig_Packet_Valid = valid_q;
  assign bus.o_Output_Data      = data_q;
  assign bus.o_Tx_Busy          = busy_q;
  assign bus.o_Done             = done_q;
  assign bus.o_Req_Error        = err_q;
endmodule
